// File: rtl/dmi_arbiter.sv
// DMI payload types and a round-robin arbiter that shares one DM request/response
// channel between NumReq DMI masters, with strictly one transaction in flight.
package dm;
    typedef struct packed {
        logic [6:0]  addr;
        logic [1:0]  op;
        logic [31:0] data;
    } dmi_req_t;

    typedef struct packed {
        logic [31:0] data;
        logic [1:0]  resp;
    } dmi_resp_t;
endpackage

module dmi_arbiter #(
    parameter int unsigned NumReq        = 2,
    parameter int unsigned TimeoutCycles = 1024,
    parameter int unsigned CntW          = $clog2(TimeoutCycles + 1)
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic [NumReq-1:0]          req_valid_i,
    output logic [NumReq-1:0]          req_ready_o,
    input  dm::dmi_req_t [NumReq-1:0]  req_i,
    output logic [NumReq-1:0]          rsp_valid_o,
    input  logic [NumReq-1:0]          rsp_ready_i,
    output dm::dmi_resp_t              rsp_o,
    output logic                       dm_req_valid_o,
    input  logic                       dm_req_ready_i,
    output dm::dmi_req_t               dm_req_o,
    input  logic                       dm_rsp_valid_i,
    output logic                       dm_rsp_ready_o,
    input  dm::dmi_resp_t              dm_rsp_i,
    output logic [NumReq-1:0]          grant_o,
    output logic                       busy_o,
    output logic                       timeout_o
);
    localparam int unsigned IdxW = $clog2(NumReq);
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP, S_DRAIN} state_e;

    state_e          state_q, state_d;
    logic [IdxW-1:0] owner_q, owner_d;
    logic [IdxW-1:0] last_q, last_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    dm::dmi_req_t    req_q, req_d;
    dm::dmi_resp_t   rsp_q, rsp_d;
    logic            drain_q, drain_d;
    logic [IdxW-1:0] pick, cand;
    logic            pick_vld;

    // First requester after the last completed owner, wrapping around.
    always_comb begin
        pick     = '0;
        pick_vld = 1'b0;
        cand     = '0;
        for (int unsigned k = 1; k <= NumReq; k++) begin
            cand = IdxW'((32'(last_q) + k) % NumReq);
            if (!pick_vld && req_valid_i[cand]) begin
                pick     = cand;
                pick_vld = 1'b1;
            end
        end
    end

    always_comb begin
        state_d        = state_q;
        owner_d        = owner_q;
        last_d         = last_q;
        cnt_d          = cnt_q;
        req_d          = req_q;
        rsp_d          = rsp_q;
        drain_d        = drain_q;
        req_ready_o    = '0;
        rsp_valid_o    = '0;
        rsp_o          = '0;
        dm_req_valid_o = 1'b0;
        dm_req_o       = '0;
        dm_rsp_ready_o = 1'b0;
        grant_o        = '0;
        busy_o         = 1'b0;
        timeout_o      = 1'b0;
        if (!rst_i) begin
            rsp_o    = rsp_q;
            dm_req_o = req_q;
            busy_o   = (state_q != S_IDLE);
            if (busy_o) grant_o[owner_q] = 1'b1;
            unique case (state_q)
                S_IDLE: begin
                    if (pick_vld) begin
                        req_ready_o[pick] = 1'b1;
                        owner_d           = pick;
                        req_d             = req_i[pick];
                        state_d           = S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    dm_req_valid_o = 1'b1;
                    if (dm_req_ready_i) begin
                        cnt_d   = '0;
                        state_d = S_WAIT;
                    end
                end
                S_WAIT: begin
                    dm_rsp_ready_o = 1'b1;
                    cnt_d          = cnt_q + 1'b1;
                    // A real response beats a timeout landing in the same cycle.
                    if (dm_rsp_valid_i) begin
                        rsp_d   = dm_rsp_i;
                        state_d = S_RESP;
                    end else if (cnt_q == CntLast) begin
                        rsp_d.data = '0;
                        rsp_d.resp = 2'h2;
                        drain_d    = 1'b1;
                        timeout_o  = 1'b1;
                        state_d    = S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid_o[owner_q] = 1'b1;
                    if (drain_q) begin
                        dm_rsp_ready_o = 1'b1;
                        if (dm_rsp_valid_i) drain_d = 1'b0;
                    end
                    if (rsp_ready_i[owner_q]) begin
                        last_d = owner_q;
                        if (drain_q && !dm_rsp_valid_i) begin
                            cnt_d   = '0;
                            state_d = S_DRAIN;
                        end else begin
                            state_d = S_IDLE;
                        end
                    end
                end
                S_DRAIN: begin
                    dm_rsp_ready_o = 1'b1;
                    cnt_d          = cnt_q + 1'b1;
                    if (dm_rsp_valid_i || cnt_q == CntLast) begin
                        drain_d = 1'b0;
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            owner_q <= '0;
            last_q  <= IdxW'(NumReq - 1);
            cnt_q   <= '0;
            req_q   <= '0;
            rsp_q   <= '0;
            drain_q <= 1'b0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            last_q  <= last_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            rsp_q   <= rsp_d;
            drain_q <= drain_d;
        end
    end
endmodule

// File: tb/tb_dmi_arbiter.sv
// Random-stimulus bench for dmi_arbiter: a per-transaction timeline model predicts
// every output each cycle from accept/issue times and the DM's chosen reply delay.
module tb_dmi_arbiter;
    localparam int NR   = 2;
    localparam int TO   = 8;
    localparam int NCYC = 6000;

    logic                   clk = 1'b0;
    logic                   rst;
    logic [NR-1:0]          req_valid, req_ready, rsp_valid, rsp_ready, grant;
    dm::dmi_req_t [NR-1:0]  req;
    dm::dmi_resp_t          rsp, dm_rsp;
    dm::dmi_req_t           dm_req;
    logic                   dm_req_valid, dm_req_ready, dm_rsp_valid, dm_rsp_ready;
    logic                   busy, timeout;

    dmi_arbiter #(.NumReq(NR), .TimeoutCycles(TO)) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid), .req_ready_o(req_ready), .req_i(req),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_o(rsp),
        .dm_req_valid_o(dm_req_valid), .dm_req_ready_i(dm_req_ready), .dm_req_o(dm_req),
        .dm_rsp_valid_i(dm_rsp_valid), .dm_rsp_ready_o(dm_rsp_ready), .dm_rsp_i(dm_rsp),
        .grant_o(grant), .busy_o(busy), .timeout_o(timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;
    int t     = 0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            if (n_bad <= 30) $display("FAIL %s at cycle %0d: got %0h, want %0h", tag, t, act, exp);
        end
    endtask

    function automatic int rr_pick(input logic [NR-1:0] v, input int last);
        for (int k = 1; k <= NR; k++)
            if (v[(last + k) % NR]) return (last + k) % NR;
        return -1;
    endfunction

    function automatic logic [NR-1:0] onehot(input int i);
        logic [NR-1:0] r;
        r    = '0;
        r[i] = 1'b1;
        return r;
    endfunction

    function automatic dm::dmi_req_t rand_req();
        dm::dmi_req_t r;
        r.addr = 7'($urandom);
        r.op   = 2'($urandom);
        r.data = $urandom;
        return r;
    endfunction

    // Master-side state and the in-flight transaction timeline (-1 = not yet known).
    logic [NR-1:0]          pend;
    dm::dmi_req_t [NR-1:0]  preq;
    bit                     act, timed;
    int                     own, last, iss_t, dly, rsp_t, hs_t, end_t;
    dm::dmi_req_t           xreq;
    dm::dmi_resp_t          xrsp, dm_data;

    initial begin
        rst = 1'b1; req_valid = '0; req = '0; rsp_ready = '0;
        dm_req_ready = 1'b0; dm_rsp_valid = 1'b0; dm_rsp = '0;
        pend = '0; preq = '0; act = 1'b0; timed = 1'b0; last = NR - 1;
        own = 0; iss_t = -1; dly = 0; rsp_t = 0; hs_t = -1; end_t = -1;
        xreq = '0; xrsp = '0; dm_data = '0;
        for (int c = 0; c < NCYC; c++) begin
            @(negedge clk);
            t++;
            rst = (c < 3) || ($urandom_range(0, 249) == 0);
            // First 200 cycles every master requests continuously: strict alternation.
            for (int m = 0; m < NR; m++) begin
                if (!pend[m]) begin
                    if (c < 200 || $urandom_range(0, 1) == 1) begin
                        pend[m] = 1'b1;
                        preq[m] = rand_req();
                    end
                end else if (c >= 200 && $urandom_range(0, 19) == 0) begin
                    pend[m] = 1'b0;
                end
            end
            req_valid    = pend;
            req          = preq;
            rsp_ready    = NR'($urandom);
            dm_req_ready = ($urandom_range(0, 9) < 6);
            dm_rsp_valid = act && (iss_t >= 0) && (dly > 0) && (t == iss_t + dly);
            if (dm_rsp_valid) dm_rsp = dm_data;
            else begin
                dm_rsp.data = $urandom;
                dm_rsp.resp = 2'($urandom);
            end
            #1;

            if (rst) begin
                chk("rst_req_ready", 64'(req_ready), 64'(0));
                chk("rst_rsp_valid", 64'(rsp_valid), 64'(0));
                chk("rst_grant", 64'(grant), 64'(0));
                chk("rst_busy", 64'(busy), 64'(0));
                chk("rst_timeout", 64'(timeout), 64'(0));
                chk("rst_dm_req_valid", 64'(dm_req_valid), 64'(0));
                chk("rst_dm_rsp_ready", 64'(dm_rsp_ready), 64'(0));
                chk("rst_rsp_o", 64'(rsp), 64'(0));
                chk("rst_dm_req_o", 64'(dm_req), 64'(0));
                act  = 1'b0;
                last = NR - 1;
                continue;
            end

            if (act && end_t >= 0 && t >= end_t) begin
                act  = 1'b0;
                last = own;
            end

            if (!act) begin
                int p;
                p = rr_pick(req_valid, last);
                chk("idle_req_ready", 64'(req_ready), 64'(p >= 0 ? onehot(p) : '0));
                chk("idle_busy", 64'(busy), 64'(0));
                chk("idle_grant", 64'(grant), 64'(0));
                chk("idle_dm_req_valid", 64'(dm_req_valid), 64'(0));
                chk("idle_rsp_valid", 64'(rsp_valid), 64'(0));
                chk("idle_dm_rsp_ready", 64'(dm_rsp_ready), 64'(0));
                chk("idle_timeout", 64'(timeout), 64'(0));
                if (p >= 0) begin
                    act = 1'b1; own = p; xreq = req[p];
                    iss_t = -1; hs_t = -1; end_t = -1;
                    pend[p] = 1'b0;
                end
                continue;
            end

            chk("busy", 64'(busy), 64'(1));
            chk("grant", 64'(grant), 64'(onehot(own)));
            chk("busy_req_ready", 64'(req_ready), 64'(0));

            if (iss_t < 0) begin
                chk("issue_dm_req_valid", 64'(dm_req_valid), 64'(1));
                chk("issue_dm_req_o", 64'(dm_req), 64'(xreq));
                chk("issue_dm_rsp_ready", 64'(dm_rsp_ready), 64'(0));
                chk("issue_rsp_valid", 64'(rsp_valid), 64'(0));
                chk("issue_timeout", 64'(timeout), 64'(0));
                if (dm_req_ready) begin
                    iss_t = t;
                    dm_data.data = $urandom;
                    dm_data.resp = 2'($urandom_range(0, 3));
                    case ($urandom_range(0, 9))
                        0, 1, 2, 3, 4: dly = $urandom_range(1, 3);
                        5:             dly = $urandom_range(TO - 1, TO);
                        6, 7:          dly = $urandom_range(TO + 1, TO + 5);
                        8:             dly = 0;
                        default:       dly = $urandom_range(4, TO - 2);
                    endcase
                    timed = (dly == 0) || (dly > TO);
                    if (timed) begin
                        xrsp.data = '0;
                        xrsp.resp = 2'h2;
                    end else begin
                        xrsp = dm_data;
                    end
                    rsp_t = iss_t + (timed ? TO : dly) + 1;
                end
            end else if (t < rsp_t) begin
                chk("wait_dm_req_valid", 64'(dm_req_valid), 64'(0));
                chk("wait_dm_rsp_ready", 64'(dm_rsp_ready), 64'(1));
                chk("wait_rsp_valid", 64'(rsp_valid), 64'(0));
                chk("wait_timeout", 64'(timeout), 64'(timed && t == iss_t + TO));
            end else if (hs_t < 0) begin
                chk("resp_rsp_valid", 64'(rsp_valid), 64'(onehot(own)));
                chk("resp_rsp_o", 64'(rsp), 64'(xrsp));
                chk("resp_dm_req_valid", 64'(dm_req_valid), 64'(0));
                chk("resp_timeout", 64'(timeout), 64'(0));
                chk("resp_dm_rsp_ready", 64'(dm_rsp_ready),
                    64'(timed && !(dly > 0 && iss_t + dly < t)));
                if (rsp_ready[own]) begin
                    hs_t = t;
                    if (!timed || (dly > 0 && iss_t + dly <= t)) end_t = t + 1;
                    else if (dly == 0)                           end_t = t + TO + 1;
                    else end_t = ((iss_t + dly < t + TO) ? iss_t + dly : t + TO) + 1;
                end
            end else begin
                chk("drain_dm_rsp_ready", 64'(dm_rsp_ready), 64'(1));
                chk("drain_rsp_valid", 64'(rsp_valid), 64'(0));
                chk("drain_dm_req_valid", 64'(dm_req_valid), 64'(0));
                chk("drain_timeout", 64'(timeout), 64'(0));
            end
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
